// File: rtl/bp_ctrl_if.sv
// Branch-prediction counter cache port: two read ports (fetch, execute) and one write port.
// master = bp_ctrl (drives addresses/write data), slave = counter cache.
interface bp_ctrl_if #(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned CWIDTH = 2
);
    logic [AWIDTH-1:0] bpc_ra0;
    logic [AWIDTH-1:0] bpc_ra1;
    logic [AWIDTH-1:0] bpc_wa;
    logic [CWIDTH-1:0] bpc_dout0;
    logic [CWIDTH-1:0] bpc_dout1;
    logic              bpc_hit0;
    logic              bpc_hit1;
    logic [CWIDTH-1:0] bpc_din;
    logic              bpc_we;

    modport master (
        output bpc_ra0, bpc_ra1, bpc_wa, bpc_din, bpc_we,
        input  bpc_dout0, bpc_dout1, bpc_hit0, bpc_hit1
    );

    modport slave (
        input  bpc_ra0, bpc_ra1, bpc_wa, bpc_din, bpc_we,
        output bpc_dout0, bpc_dout1, bpc_hit0, bpc_hit1
    );
endinterface

// File: rtl/bp_ctrl.sv
// Saturating-counter branch predictor controller with a one-entry write buffer.
// Optional feature macro: BP_PERF_EN (branch / mispredict event counters).
module bp_ctrl #(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned CWIDTH = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [AWIDTH-1:0] pc_if,
    input  logic              if_valid,
    input  logic              stall,
    input  logic              flush,
    output logic              pred_taken,
    input  logic              ex_valid,
    input  logic              ex_is_branch,
    input  logic              ex_taken,
    input  logic [AWIDTH-1:0] ex_pc,
    output logic              mispredict,
    bp_ctrl_if.master         bpc,
    output logic [31:0]       perf_branches,
    output logic [31:0]       perf_mispredicts
);

    localparam int unsigned PERF_W = 32;
    localparam logic [CWIDTH-1:0] CNT_MAX = '1;
    localparam logic [CWIDTH-1:0] CNT_WNT = CNT_MAX >> 1;

    typedef struct packed {
        logic vld;
        logic pred;
    } stage_t;

    typedef struct packed {
        logic              vld;
        logic [AWIDTH-1:0] addr;
        logic [CWIDTH-1:0] cnt;
    } wbuf_t;

    stage_t            id_q, id_d, ex_q, ex_d;
    wbuf_t             wb_q, wb_d;
    logic              mispredict_q, mispredict_d;
    logic              accept_c;
    logic [AWIDTH-1:0] ex_addr_c;
    logic [CWIDTH-1:0] old_cnt_c, new_cnt_c;
    logic [3:0]        unused_pc_lsb_c;

    // Byte PCs map to word addresses; the low two bits never reach the cache.
    assign unused_pc_lsb_c = {pc_if[1:0], ex_pc[1:0]};
    assign ex_addr_c       = {2'b00, ex_pc[AWIDTH-1:2]};
    assign bpc.bpc_ra0     = {2'b00, pc_if[AWIDTH-1:2]};
    assign bpc.bpc_ra1     = ex_addr_c;
    assign bpc.bpc_wa      = wb_q.addr;
    assign bpc.bpc_din     = wb_q.cnt;
    assign bpc.bpc_we      = wb_q.vld;
    assign pred_taken      = if_valid & bpc.bpc_hit0 & bpc.bpc_dout0[CWIDTH-1];
    assign mispredict      = mispredict_q;
    assign accept_c        = ex_valid & ex_is_branch & ~stall;

    // Prediction pipe: flush beats stall.
    always_comb begin
        id_d = id_q;
        ex_d = ex_q;
        if (flush) begin
            id_d = '0;
            ex_d = '0;
        end else if (!stall) begin
            id_d.vld  = if_valid;
            id_d.pred = pred_taken;
            ex_d      = id_q;
        end
    end

    // Counter update; the buffered value is fresher than the cache for the same address.
    always_comb begin
        old_cnt_c = CNT_WNT;
        if (wb_q.vld && (wb_q.addr == ex_addr_c)) begin
            old_cnt_c = wb_q.cnt;
        end else if (bpc.bpc_hit1) begin
            old_cnt_c = bpc.bpc_dout1;
        end
        new_cnt_c = old_cnt_c;
        if (ex_taken) begin
            if (old_cnt_c != CNT_MAX) new_cnt_c = old_cnt_c + CWIDTH'(1);
        end else begin
            if (old_cnt_c != '0) new_cnt_c = old_cnt_c - CWIDTH'(1);
        end

        wb_d     = wb_q;
        wb_d.vld = 1'b0;
        if (accept_c) begin
            wb_d.vld  = 1'b1;
            wb_d.addr = ex_addr_c;
            wb_d.cnt  = new_cnt_c;
        end

        mispredict_d = accept_c & ((ex_q.vld & ex_q.pred) != ex_taken);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_q         <= '0;
            ex_q         <= '0;
            wb_q         <= '0;
            mispredict_q <= 1'b0;
        end else begin
            id_q         <= id_d;
            ex_q         <= ex_d;
            wb_q         <= wb_d;
            mispredict_q <= mispredict_d;
        end
    end

`ifdef BP_PERF_EN
    logic [PERF_W-1:0] perf_branches_q, perf_branches_d;
    logic [PERF_W-1:0] perf_mispredicts_q, perf_mispredicts_d;

    always_comb begin
        perf_branches_d    = perf_branches_q + PERF_W'(accept_c);
        perf_mispredicts_d = perf_mispredicts_q + PERF_W'(mispredict_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_branches_q    <= '0;
            perf_mispredicts_q <= '0;
        end else begin
            perf_branches_q    <= perf_branches_d;
            perf_mispredicts_q <= perf_mispredicts_d;
        end
    end

    assign perf_branches    = perf_branches_q;
    assign perf_mispredicts = perf_mispredicts_q;
`else
    assign perf_branches    = '0;
    assign perf_mispredicts = '0;
`endif

endmodule

// File: tb/tb_bp_ctrl.sv
// Directed self-checking bench for bp_ctrl: expected write-port/mispredict results are
// queued when a cycle is driven and compared after the following clock edge.
module tb_bp_ctrl;

    logic        clk;
    logic        reset_n;
    logic [31:0] pc_if;
    logic        if_valid;
    logic        stall;
    logic        flush;
    logic        pred_taken;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_taken;
    logic [31:0] ex_pc;
    logic        mispredict;
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;

    bp_ctrl_if #(.AWIDTH(32), .CWIDTH(2)) bus ();

    bp_ctrl #(.AWIDTH(32), .CWIDTH(2)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .pc_if            (pc_if),
        .if_valid         (if_valid),
        .stall            (stall),
        .flush            (flush),
        .pred_taken       (pred_taken),
        .ex_valid         (ex_valid),
        .ex_is_branch     (ex_is_branch),
        .ex_taken         (ex_taken),
        .ex_pc            (ex_pc),
        .mispredict       (mispredict),
        .bpc              (bus),
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
    );

    typedef struct {
        logic        we;
        logic [31:0] wa;
        logic [1:0]  din;
        logic        misp;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    total_cnt = 0;
    int    pass_cnt  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Queue the result expected one edge after the current inputs, then advance and compare.
    task automatic step(input string tag, input logic we, input logic [31:0] wa,
                        input logic [1:0] din, input logic misp);
        exp_t  e;
        string t;
        e.we = we; e.wa = wa; e.din = din; e.misp = misp;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        check({t, "_we"}, 32'(bus.bpc_we), 32'(e.we));
        check({t, "_misp"}, 32'(mispredict), 32'(e.misp));
        if (e.we) begin
            check({t, "_wa"}, bus.bpc_wa, e.wa);
            check({t, "_din"}, 32'(bus.bpc_din), 32'(e.din));
        end
    endtask

    task automatic fetch(input logic v, input logic hit, input logic [1:0] cnt);
        if_valid      = v;
        bus.bpc_hit0  = hit;
        bus.bpc_dout0 = cnt;
    endtask

    task automatic resolve(input logic v, input logic [31:0] pc, input logic tk,
                           input logic hit, input logic [1:0] cnt);
        ex_valid      = v;
        ex_is_branch  = v;
        ex_pc         = pc;
        ex_taken      = tk;
        bus.bpc_hit1  = hit;
        bus.bpc_dout1 = cnt;
    endtask

    initial begin
        logic [31:0] exp_br, exp_mp;
        reset_n = 1'b0;
        pc_if = 32'h0; stall = 1'b0; flush = 1'b0;
        fetch(1'b0, 1'b0, 2'b00);
        resolve(1'b0, 32'h0, 1'b0, 1'b0, 2'b00);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_we", 32'(bus.bpc_we), 32'd0);
        check("rst_misp", 32'(mispredict), 32'd0);
        check("rst_perf_br", perf_branches, 32'd0);
        check("rst_perf_mp", perf_mispredicts, 32'd0);
        reset_n = 1'b1;

        // Fetch-side prediction is combinational
        pc_if = 32'h200;
        fetch(1'b1, 1'b1, 2'b10);
        #1;
        check("pred_hit_10", 32'(pred_taken), 32'd1);
        check("ra0_map", bus.bpc_ra0, 32'h80);
        fetch(1'b1, 1'b0, 2'b10);
        #1;
        check("pred_miss", 32'(pred_taken), 32'd0);
        fetch(1'b1, 1'b1, 2'b01);
        #1;
        check("pred_hit_01", 32'(pred_taken), 32'd0);
        fetch(1'b0, 1'b1, 2'b11);
        #1;
        check("pred_no_ifv", 32'(pred_taken), 32'd0);
        step("idle0", 1'b0, 32'h0, 2'b00, 1'b0);
        step("idle1", 1'b0, 32'h0, 2'b00, 1'b0);

        // Cold cache, 0x100 taken three times back-to-back; fetched preds 0,0,1
        fetch(1'b1, 1'b0, 2'b00);
        step("cold_fA", 1'b0, 32'h0, 2'b00, 1'b0);
        fetch(1'b1, 1'b0, 2'b00);
        step("cold_fB", 1'b0, 32'h0, 2'b00, 1'b0);
        fetch(1'b1, 1'b1, 2'b11);
        resolve(1'b1, 32'h100, 1'b1, 1'b0, 2'b00);
        #1;
        check("ra1_map", bus.bpc_ra1, 32'h40);
        step("cold_r1", 1'b1, 32'h40, 2'b10, 1'b1);
        fetch(1'b0, 1'b0, 2'b00);
        step("cold_r2", 1'b1, 32'h40, 2'b11, 1'b1);
        step("cold_r3", 1'b1, 32'h40, 2'b11, 1'b0);
        resolve(1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
        step("cold_idle", 1'b0, 32'h0, 2'b00, 1'b0);

        // Saturation at both ends, plus a plain decrement
        resolve(1'b1, 32'h300, 1'b0, 1'b1, 2'b00);
        step("sat_low", 1'b1, 32'hC0, 2'b00, 1'b0);
        resolve(1'b1, 32'h304, 1'b1, 1'b1, 2'b11);
        step("sat_high", 1'b1, 32'hC1, 2'b11, 1'b1);
        resolve(1'b1, 32'h400, 1'b0, 1'b1, 2'b11);
        step("dec_11", 1'b1, 32'h100, 2'b10, 1'b0);

        // Flush: same-cycle resolution unaffected, later one sees EX invalid
        resolve(1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
        fetch(1'b1, 1'b1, 2'b11);
        step("fl_fG", 1'b0, 32'h0, 2'b00, 1'b0);
        step("fl_fH", 1'b0, 32'h0, 2'b00, 1'b0);
        fetch(1'b0, 1'b0, 2'b00);
        flush = 1'b1;
        resolve(1'b1, 32'h600, 1'b1, 1'b0, 2'b00);
        step("fl_same", 1'b1, 32'h180, 2'b10, 1'b0);
        flush = 1'b0;
        resolve(1'b1, 32'h500, 1'b1, 1'b0, 2'b00);
        step("fl_after", 1'b1, 32'h140, 2'b10, 1'b1);

        // Stall holds the pipe and ignores resolution
        resolve(1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
        fetch(1'b1, 1'b1, 2'b11);
        step("st_fK", 1'b0, 32'h0, 2'b00, 1'b0);
        step("st_fL", 1'b0, 32'h0, 2'b00, 1'b0);
        stall = 1'b1;
        fetch(1'b1, 1'b0, 2'b00);
        resolve(1'b1, 32'h700, 1'b0, 1'b1, 2'b10);
        step("st_hold1", 1'b0, 32'h0, 2'b00, 1'b0);
        step("st_hold2", 1'b0, 32'h0, 2'b00, 1'b0);
        stall = 1'b0;
        fetch(1'b0, 1'b0, 2'b00);
        step("st_rel", 1'b1, 32'h1C0, 2'b01, 1'b1);
        resolve(1'b1, 32'h700, 1'b1, 1'b1, 2'b00);
        step("st_bypass", 1'b1, 32'h1C0, 2'b10, 1'b0);
        resolve(1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
        step("st_idle", 1'b0, 32'h0, 2'b00, 1'b0);

        // Event counters: five resolutions, two mispredicts, after a fresh reset
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        resolve(1'b1, 32'h800, 1'b1, 1'b0, 2'b00);
        step("pf_r1", 1'b1, 32'h200, 2'b10, 1'b1);
        resolve(1'b1, 32'h804, 1'b0, 1'b0, 2'b00);
        step("pf_r2", 1'b1, 32'h201, 2'b00, 1'b0);
        resolve(1'b1, 32'h808, 1'b0, 1'b0, 2'b00);
        step("pf_r3", 1'b1, 32'h202, 2'b00, 1'b0);
        resolve(1'b1, 32'h80C, 1'b1, 1'b0, 2'b00);
        step("pf_r4", 1'b1, 32'h203, 2'b10, 1'b1);
        resolve(1'b1, 32'h810, 1'b0, 1'b0, 2'b00);
        step("pf_r5", 1'b1, 32'h204, 2'b00, 1'b0);
        resolve(1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
        step("pf_idle", 1'b0, 32'h0, 2'b00, 1'b0);
`ifdef BP_PERF_EN
        exp_br = 32'd5; exp_mp = 32'd2;
`else
        exp_br = 32'd0; exp_mp = 32'd0;
`endif
        check("perf_branches", perf_branches, exp_br);
        check("perf_mispredicts", perf_mispredicts, exp_mp);

        // Reset in the middle of a pending write drops it at once
        resolve(1'b1, 32'h900, 1'b1, 1'b0, 2'b00);
        step("mid_r", 1'b1, 32'h240, 2'b10, 1'b1);
        resolve(1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
        reset_n = 1'b0;
        #1;
        check("mid_rst_we", 32'(bus.bpc_we), 32'd0);
        check("mid_rst_misp", 32'(mispredict), 32'd0);
        check("mid_rst_perf_br", perf_branches, 32'd0);
        check("mid_rst_perf_mp", perf_mispredicts, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step("mid_after", 1'b0, 32'h0, 2'b00, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
